// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause-22 MDIO PHY-side responder with a 32x16 register model.
// MDC and MDIO are resynchronised to clk; bits are sampled on MDC rise and driven on MDC fall.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter bit          BCAST_EN     = 1'b1,
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h001C,
  parameter logic [15:0] PHY_ID2      = 16'hC915
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_out,
  output logic        mdio_en,
  input  logic        link_up_i,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [7:0]  frame_err_cnt
);
  typedef enum logic [2:0] {HUNT, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA} state_t;
  state_t state;
  logic [1:0] mdc_s, mdio_s;
  logic mdc_q, rise, fall, din, abort, is_read, match, ta_hi;
  logic [5:0] pre_cnt;
  logic [3:0] cnt;
  logic [4:0] phyad, regad;
  logic [15:0] shreg, rdata, wd;
  logic [15:0] regs [32];

  function automatic logic [15:0] dflt(input int i);
    return i == 0 ? 16'h1140 : i == 1 ? 16'h7949 : i == 2 ? PHY_ID1 : i == 3 ? PHY_ID2 : 16'h0000;
  endfunction

  assign din  = mdio_s[1];
  assign rise = mdc_s[1] & ~mdc_q;
  assign fall = ~mdc_s[1] & mdc_q;
  assign wd   = {shreg[14:0], din};

  always_comb begin
    rdata = regad == 5'd0 ? {1'b0, regs[0][14:0]} :
            regad == 5'd1 ? (16'h7949 & 16'hFFFB) | {13'd0, link_up_i, 2'd0} :
            regad == 5'd2 ? PHY_ID1 :
            regad == 5'd3 ? PHY_ID2 : regs[regad];
    abort = rise && ((state == ST && !din) ||
                     (state == OP && cnt == 4'd1 && is_read == din) ||
                     (state == TA && cnt == 4'd1 && !is_read && !(ta_hi && !din)));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mdc_s <= 2'b00;
      mdio_s <= 2'b00;
      mdc_q <= 1'b0;
      state <= HUNT;
      pre_cnt <= 6'd0;
      cnt <= 4'd0;
      phyad <= 5'd0;
      regad <= 5'd0;
      shreg <= 16'h0000;
      is_read <= 1'b0;
      match <= 1'b0;
      ta_hi <= 1'b0;
      mdio_en <= 1'b0;
      mdio_out <= 1'b1;
      wr_valid <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= 16'h0000;
      frame_err_cnt <= 8'd0;
      for (int i = 0; i < 32; i++) regs[i] <= dflt(i);
    end else begin
      mdc_s <= {mdc_s[0], mdc_i};
      mdio_s <= {mdio_s[0], mdio_i};
      mdc_q <= mdc_s[1];
      wr_valid <= 1'b0;
      if (abort) begin
        state <= HUNT;
        pre_cnt <= 6'd0;
        frame_err_cnt <= frame_err_cnt + {7'd0, frame_err_cnt != 8'hFF};
      end else if (rise) begin
        case (state)
          HUNT: begin
            pre_cnt <= din ? pre_cnt + {5'd0, pre_cnt != 6'd32} : 6'd0;
            if (!din && pre_cnt >= 6'(PREAMBLE_MIN)) state <= ST;
          end
          ST: begin
            state <= OP;
            cnt <= 4'd0;
          end
          OP: begin
            // First OP bit alone decides read (10) vs write (01); the second must differ
            is_read <= cnt == 4'd0 ? din : is_read;
            cnt <= cnt == 4'd0 ? 4'd1 : 4'd0;
            if (cnt == 4'd1) state <= PHYAD;
          end
          PHYAD: begin
            phyad <= {phyad[3:0], din};
            cnt <= cnt == 4'd4 ? 4'd0 : cnt + 4'd1;
            if (cnt == 4'd4) state <= REGAD;
          end
          REGAD: begin
            regad <= {regad[3:0], din};
            cnt <= cnt == 4'd4 ? 4'd0 : cnt + 4'd1;
            if (cnt == 4'd4) begin
              state <= TA;
              match <= phyad == PHY_ADDR || (!is_read && BCAST_EN && phyad == 5'd0);
            end
          end
          TA: begin
            ta_hi <= din;
            cnt <= cnt == 4'd0 ? 4'd1 : 4'd0;
            if (cnt == 4'd0) shreg <= rdata;
            else state <= is_read ? RDATA : WDATA;
          end
          WDATA: begin
            shreg <= wd;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state <= HUNT;
              pre_cnt <= 6'd0;
              if (match) begin
                wr_valid <= 1'b1;
                wr_addr <= regad;
                wr_data <= wd;
                if (regad == 5'd0 && wd[15]) for (int i = 0; i < 32; i++) regs[i] <= dflt(i);
                else if (regad == 5'd0 || regad > 5'd3) regs[regad] <= wd;
              end
            end
          end
          RDATA: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state <= HUNT;
              pre_cnt <= 6'd0;
            end
          end
          default: state <= HUNT;
        endcase
      end else if (fall) begin
        if (state == TA && cnt == 4'd1 && is_read && match) begin
          mdio_en <= 1'b1;
          mdio_out <= 1'b0;
        end else if (state == RDATA && is_read && match) begin
          mdio_out <= shreg[15];
          shreg <= {shreg[14:0], 1'b0};
        end else begin
          mdio_en <= 1'b0;
          mdio_out <= 1'b1;
        end
      end
    end
  end
endmodule
